// File: rtl/led_bar_pkg.sv
// -----------------------------------------------------------------------------
// led_bar_pkg
// Shared definitions for the LED bargraph:
//   mode_t     - display mode encoding driven on the 2-bit mode input
//   cnt_width  - bit width needed for a down-counter loaded with a cycle count
// -----------------------------------------------------------------------------
package led_bar_pkg;

    typedef enum logic [1:0] {
        MODE_BAR      = 2'b00,
        MODE_DOT      = 2'b01,
        MODE_BAR_PEAK = 2'b10,
        MODE_DOT_PEAK = 2'b11
    } mode_t;

    // Width of a counter that must hold the value 'cycles' itself (clog2(cycles+1)).
    function automatic int cnt_width(input longint unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/led_peak_tracker.sv
// -----------------------------------------------------------------------------
// led_peak_tracker
// Peak capture, hold and step-wise decay for the bargraph peak indicator.
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous active-high reset
//   sample       in   clamped level sample (0..NUM_LEDS)
//   sample_valid in   sample is taken on this edge
//   cur          in   currently displayed level (registered in the top)
//   peak         out  registered peak value
// -----------------------------------------------------------------------------
module led_peak_tracker
    import led_bar_pkg::*;
#(
    parameter int LEVEL_W      = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int DECAY_CYCLES = 5_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] sample,
    input  logic               sample_valid,
    input  logic [LEVEL_W-1:0] cur,
    output logic [LEVEL_W-1:0] peak
);

    localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
    localparam int DECAY_W = cnt_width(DECAY_CYCLES);

    logic [HOLD_W-1:0]  hold_cnt;
    logic [DECAY_W-1:0] decay_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak      <= '0;
            hold_cnt  <= '0;
            decay_cnt <= '0;
        end else if (sample_valid && (sample >= peak)) begin
            // A new peak wins over any hold or decay activity this cycle.
            peak      <= sample;
            hold_cnt  <= HOLD_W'(HOLD_CYCLES);
            decay_cnt <= DECAY_W'(DECAY_CYCLES);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end else if (peak > cur) begin
            // A count of 1 means this cycle is the last of the decay interval.
            if (decay_cnt <= DECAY_W'(1)) begin
                peak      <= peak - LEVEL_W'(1);
                decay_cnt <= DECAY_W'(DECAY_CYCLES);
            end else begin
                decay_cnt <= decay_cnt - DECAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_bargraph.sv
// -----------------------------------------------------------------------------
// led_bargraph
// Level-to-LED bargraph with BAR/DOT modes, optional peak marker and an
// overrange blink. Samples are captured on one edge and shown on the next.
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous active-high reset
//   level_in     in   unsigned level sample
//   level_valid  in   level_in is sampled on this edge
//   mode         in   00 BAR, 01 DOT, 10 BAR_PEAK, 11 DOT_PEAK
//   led_out      out  registered LED drive, bit 0 = lowest LED
//   peak_level   out  registered peak value
//   overrange    out  registered, last sample exceeded NUM_LEDS
// -----------------------------------------------------------------------------
module led_bargraph
    import led_bar_pkg::*;
#(
    parameter int NUM_LEDS     = 10,
    parameter int LEVEL_W      = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int DECAY_CYCLES = 5_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LEVEL_W-1:0]  level_in,
    input  logic                level_valid,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [LEVEL_W-1:0]  peak_level,
    output logic                overrange
);

    if (NUM_LEDS < 2 || NUM_LEDS > 64) begin : g_bad_num_leds
        $error("led_bargraph: NUM_LEDS must be within 2..64");
    end
    if ((longint'(1) << LEVEL_W) <= longint'(NUM_LEDS)) begin : g_bad_level_w
        $error("led_bargraph: 2**LEVEL_W must exceed NUM_LEDS");
    end

    localparam int                 BLINK_W   = cnt_width(BLINK_CYCLES);
    localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_LEDS);

    logic [LEVEL_W-1:0]  cur;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_on;
    logic                over_now;
    logic [LEVEL_W-1:0]  sample;
    logic [NUM_LEDS-1:0] bar;
    logic [NUM_LEDS-1:0] dot;
    logic [NUM_LEDS-1:0] peak_dot;
    logic [NUM_LEDS-1:0] pattern;

    assign over_now = (level_in > MAX_LEVEL);
    assign sample   = over_now ? MAX_LEVEL : level_in;

    led_peak_tracker #(
        .LEVEL_W      (LEVEL_W),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .DECAY_CYCLES (DECAY_CYCLES)
    ) u_peak (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (level_valid),
        .cur          (cur),
        .peak         (peak_level)
    );

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bar      = '0;
        dot      = '0;
        peak_dot = '0;
        pattern  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            bar[i]      = (i < int'(cur));
            dot[i]      = (i + 1 == int'(cur));
            peak_dot[i] = (i + 1 == int'(peak_level));
        end
        case (mode_t'(mode))
            MODE_BAR:      pattern = bar;
            MODE_DOT:      pattern = dot;
            MODE_BAR_PEAK: pattern = bar | peak_dot;
            MODE_DOT_PEAK: pattern = dot | peak_dot;
            default:       pattern = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            overrange <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            led_out   <= '0;
        end else begin
            // Output edge: show what was captured on the previous edge.
            led_out <= overrange ? {NUM_LEDS{blink_on}} : pattern;

            // Blink runs only while overrange is held; a rising overrange
            // (below) restarts it and the two branches are mutually exclusive.
            if (overrange) begin
                if (blink_cnt <= BLINK_W'(1)) begin
                    blink_on  <= ~blink_on;
                    blink_cnt <= BLINK_W'(BLINK_CYCLES);
                end else begin
                    blink_cnt <= blink_cnt - BLINK_W'(1);
                end
            end

            // Capture edge.
            if (level_valid) begin
                cur       <= sample;
                overrange <= over_now;
                if (over_now && !overrange) begin
                    blink_on  <= 1'b1;
                    blink_cnt <= BLINK_W'(BLINK_CYCLES);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_bargraph.sv
// -----------------------------------------------------------------------------
// tb_led_bargraph
// Self-checking bench for led_bargraph with short timing parameters. A
// behavioural model tracks displayed level, peak, hold/decay progress and the
// age of the overrange condition; every clock the DUT outputs are compared.
// -----------------------------------------------------------------------------
module tb_led_bargraph;
    import led_bar_pkg::*;

    localparam int N     = 10;
    localparam int LW    = 4;
    localparam int HOLD  = 4;
    localparam int DECAY = 2;
    localparam int BLINK = 3;
    localparam int ALL   = (1 << N) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [LW-1:0] level_in;
    logic          level_valid;
    logic [1:0]    mode;
    logic [N-1:0]  led_out;
    logic [LW-1:0] peak_level;
    logic          overrange;

    int n_checks = 0;
    int n_errors = 0;
    string phase = "init";

    // Behavioural model state.
    int m_cur, m_peak, m_hold_left, m_decay_elapsed, m_blink_age, exp_led;
    bit m_over;

    led_bargraph #(
        .NUM_LEDS     (N),
        .LEVEL_W      (LW),
        .HOLD_CYCLES  (HOLD),
        .DECAY_CYCLES (DECAY),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .level_in    (level_in),
        .level_valid (level_valid),
        .mode        (mode),
        .led_out     (led_out),
        .peak_level  (peak_level),
        .overrange   (overrange)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s.%s: observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic int pattern_of(input int md, input int c, input int p);
        int bar, dot, pk;
        bar = (1 << c) - 1;
        dot = (c == 0) ? 0 : (1 << (c - 1));
        pk  = (p == 0) ? 0 : (1 << (p - 1));
        case (md)
            0:       return bar;
            1:       return dot;
            2:       return bar | pk;
            default: return dot | pk;
        endcase
    endfunction

    // One rising edge of the model, using the pre-edge model state.
    task automatic model_edge(input bit rst, input bit vld, input int lvl, input int md);
        int s;
        if (rst) begin
            m_cur = 0; m_peak = 0; m_hold_left = 0; m_decay_elapsed = 0;
            m_blink_age = 0; m_over = 0; exp_led = 0;
            return;
        end
        if (m_over) begin
            exp_led = (((m_blink_age / BLINK) % 2) == 0) ? ALL : 0;
            m_blink_age++;
        end else begin
            exp_led = pattern_of(md, m_cur, m_peak);
        end
        s = (lvl > N) ? N : lvl;
        if (vld && s >= m_peak) begin
            m_peak = s; m_hold_left = HOLD; m_decay_elapsed = 0;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end else if (m_peak > m_cur) begin
            m_decay_elapsed++;
            if (m_decay_elapsed == DECAY) begin
                m_peak--;
                m_decay_elapsed = 0;
            end
        end
        if (vld) begin
            if (lvl > N && !m_over) m_blink_age = 0;
            m_cur  = s;
            m_over = (lvl > N);
        end
    endtask

    task automatic step(input bit rst, input bit vld, input int lvl, input logic [1:0] md);
        reset       = rst;
        level_valid = vld;
        level_in    = LW'(lvl);
        mode        = md;
        @(posedge clk);
        model_edge(rst, vld, lvl, int'(md));
        #1;
        check("led_out",    64'(led_out),    64'(exp_led));
        check("peak_level", 64'(peak_level), 64'(m_peak));
        check("overrange",  64'(overrange),  64'(m_over));
    endtask

    initial begin
        bit found;
        reset = 1'b1; level_valid = 1'b0; level_in = '0; mode = MODE_BAR;

        phase = "reset";
        step(1, 0, 0, MODE_BAR);
        step(1, 1, 9, MODE_BAR);
        check("reset_led", 64'(led_out), 64'(0));

        // Every level in BAR mode, idle cycles after each to watch latency and blink.
        phase = "bar_sweep";
        for (int l = 0; l < 16; l++) begin
            step(0, 1, l, MODE_BAR);
            for (int k = 0; k < 7; k++) step(0, 0, 0, MODE_BAR);
        end
        check("bar_sweep_over", 64'(overrange), 64'(1));

        // Peak hold then decay towards a lower displayed level.
        phase = "peak_decay";
        step(1, 0, 0, MODE_BAR_PEAK);
        step(0, 1, 7, MODE_BAR_PEAK);
        step(0, 1, 2, MODE_BAR_PEAK);
        check("peak_held", 64'(peak_level), 64'(7));
        for (int k = 0; k < 20; k++) step(0, 0, 0, MODE_BAR_PEAK);
        check("peak_floor", 64'(peak_level), 64'(2));
        check("peak_led",   64'(led_out),    64'('h003));

        // DOT pattern and a mode switch with no new sample.
        phase = "dot_mode";
        step(1, 0, 0, MODE_DOT);
        step(0, 1, 5, MODE_DOT);
        step(0, 0, 0, MODE_DOT);
        check("dot5", 64'(led_out), 64'('h010));
        step(0, 1, 0, MODE_DOT);
        step(0, 0, 0, MODE_DOT);
        check("dot0", 64'(led_out), 64'('h000));
        step(0, 1, 5, MODE_DOT);
        step(0, 0, 0, MODE_DOT);
        step(0, 0, 0, MODE_BAR);
        check("bar5_switch", 64'(led_out), 64'('h01F));

        // New peak arriving on the very cycle a decay step is due.
        phase = "capture_vs_decay";
        step(1, 0, 0, MODE_BAR_PEAK);
        step(0, 1, 6, MODE_BAR_PEAK);
        step(0, 1, 0, MODE_BAR_PEAK);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_hold_left == 0 && m_peak == 6 && m_peak > m_cur &&
                m_decay_elapsed == DECAY - 1)
                found = 1;
            else
                step(0, 0, 0, MODE_BAR_PEAK);
        end
        check("decay_step_reached", 64'(found), 64'(1));
        step(0, 1, 8, MODE_BAR_PEAK);
        check("capture_wins", 64'(peak_level), 64'(8));
        for (int k = 0; k < 4; k++) step(0, 0, 0, MODE_BAR_PEAK);
        check("hold_restarted", 64'(peak_level), 64'(8));
        for (int k = 0; k < 8; k++) step(0, 0, 0, MODE_BAR_PEAK);

        // Reset in the middle of the blink on-phase.
        phase = "reset_mid_blink";
        step(1, 0, 0, MODE_BAR);
        step(0, 1, 12, MODE_BAR);
        step(0, 0, 0, MODE_BAR);
        check("blink_on", 64'(led_out), 64'(ALL));
        step(1, 0, 0, MODE_BAR);
        check("rst_led",  64'(led_out),    64'(0));
        check("rst_peak", 64'(peak_level), 64'(0));
        check("rst_over", 64'(overrange),  64'(0));
        step(0, 1, 3, MODE_BAR);
        step(0, 0, 0, MODE_BAR);
        check("after_rst", 64'(led_out), 64'('h007));
        for (int k = 0; k < 8; k++) step(0, 0, 0, MODE_BAR);

        // Randomized traffic against the model.
        phase = "random";
        for (int k = 0; k < 500; k++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_bargraph.md
LED_BARGRAPH -- requirements
Module: led_bargraph

Interface
REQ-001 Parameter NUM_LEDS, 10, number of LED outputs (2..64).
REQ-002 Parameter LEVEL_W, 4, level input width; 2**LEVEL_W > NUM_LEDS SHALL hold (elaboration error otherwise).
REQ-003 Parameter HOLD_CYCLES, 50_000_000, peak hold time in clk cycles (>=1).
REQ-004 Parameter DECAY_CYCLES, 5_000_000, clk cycles per one-LED peak decay step (>=1).
REQ-005 Parameter BLINK_CYCLES, 12_500_000, overrange blink half-period in clk cycles (>=1).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 level_in  input  LEVEL_W  unsigned level sample.
REQ-009 level_valid  input  1  level_in sampled on a clk edge where high.
REQ-010 mode  input  2  display mode: 00 BAR, 01 DOT, 10 BAR_PEAK, 11 DOT_PEAK.
REQ-011 led_out  output  NUM_LEDS  registered LED drive, bit 0 = lowest LED.
REQ-012 peak_level  output  LEVEL_W  registered current peak value.
REQ-013 overrange  output  1  registered; high while the last sample exceeded NUM_LEDS.

Function
REQ-014 On level_valid, cur SHALL load min(level_in, NUM_LEDS); overrange SHALL load (level_in > NUM_LEDS); no valid -> both hold.
REQ-015 led_out SHALL reflect a sample exactly 2 clk cycles after the edge where level_valid was high (capture edge + output edge).
REQ-016 BAR: led_out[i] = 1 for all i < cur; cur = 0 -> all off; cur = NUM_LEDS -> all on.
REQ-017 DOT: only led_out[cur-1] on; cur = 0 -> all off.
REQ-018 BAR_PEAK / DOT_PEAK: BAR / DOT pattern OR'd with led_out[peak-1]; peak = 0 adds nothing.
REQ-019 Peak capture: sample with min(level_in, NUM_LEDS) >= peak SHALL set peak to it and reload hold counter to HOLD_CYCLES and decay counter to DECAY_CYCLES.
REQ-020 Hold: while hold counter > 0 it SHALL decrement once per cycle; peak unchanged.
REQ-021 Decay: hold counter = 0 and peak > cur -> decay counter decrements per cycle; on reaching 0, peak SHALL decrement by 1 and decay counter reload to DECAY_CYCLES.
REQ-022 Peak SHALL never fall below cur; decay stops when peak = cur.
REQ-023 Capture (REQ-019) SHALL take precedence over a decay step in the same cycle.
REQ-024 Overrange: while overrange = 1, led_out SHALL be all-ones and all-zeros alternately, each phase BLINK_CYCLES cycles, regardless of mode, starting with the all-ones phase.
REQ-025 Blink phase counter SHALL restart (all-ones first) each time overrange rises; a valid in-range sample SHALL clear overrange and restore the mode pattern on the next output edge.
REQ-026 Mode change SHALL take effect on the next output edge (1 cycle); it SHALL NOT alter cur, peak or counters.
REQ-027 Peak tracking SHALL continue in all modes, including during overrange (peak = NUM_LEDS on overrange samples).

Reset
REQ-028 reset high at a clk edge SHALL force cur = 0, peak = 0, hold/decay/blink counters = 0, overrange = 0, blink phase = on, led_out = 0, peak_level = 0.
REQ-029 reset SHALL override level_valid in the same cycle; a mid-hold or mid-blink reset SHALL abandon that activity completely.

Structure
REQ-030 Shared package led_bar_pkg SHALL hold the mode encoding (BAR, DOT, BAR_PEAK, DOT_PEAK) and the counter-width helper function (clog2 of cycle parameters).
REQ-031 Peak capture/hold/decay SHALL be one sub-module, led_peak_tracker (ports: clk, reset, sample, sample_valid, cur, peak); pattern generation and blink stay in led_bargraph.

Verification (NUM_LEDS=10, LEVEL_W=4, HOLD_CYCLES=4, DECAY_CYCLES=2, BLINK_CYCLES=3)
REQ-032 BAR, levels 0..15 each with valid -> led_out 0x000, 0x001, 0x003 ... 0x3FF for 10; 11..15 -> blink 0x3FF x3 / 0x000 x3, overrange = 1; all outputs 2 cycles after the valid edge.
REQ-033 BAR_PEAK, sample 7 then 2 -> peak_level 7 for 4 cycles after the capture, then 6,5,4,3,2 every 2 cycles; led_out 0x003 | peak bit; stops at 2.
REQ-034 DOT, sample 5 -> led_out 0x010; sample 0 -> 0x000; switch mode to BAR with cur = 5 -> 0x01F on the next edge.
REQ-035 Peak 6 decaying, sample 8 arrives on a decay-step cycle -> peak_level 8, hold restarts (8 for 4 cycles).
REQ-036 Sample 12 (blinking), reset asserted mid-on phase -> next edge all outputs 0; sample 3 after reset -> 0x007 with no blink.
